// File: rtl/jtkcpu_stack.sv
// Stack push/pull engine: serialises the register mask into byte accesses on S or U
// and stalls the sequencer until the frame is complete.
module jtkcpu_stack (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        psh_go,
  input  logic        pul_go,
  input  logic        psh_all,
  input  logic        psh_cc,
  input  logic        psh_pc,
  input  logic        rti_cc,
  input  logic        rti_other,
  input  logic [7:0]  postbyte,
  input  logic        us_sel,
  input  logic        cc_e,
  input  logic [7:0]  rcc,
  input  logic [7:0]  ra,
  input  logic [7:0]  rb,
  input  logic [7:0]  rdp,
  input  logic [15:0] rx,
  input  logic [15:0] ry,
  input  logic [15:0] rother,
  input  logic [15:0] rpc,
  input  logic [15:0] sp_in,
  input  logic        mem_busy,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        we,
  output logic        rd,
  output logic        stack_busy,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic        pul_we,
  output logic [2:0]  pul_sel,
  output logic        pul_hi,
  output logic [7:0]  pul_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] PULL = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state;
  logic [7:0]  mask;
  logic [15:0] sp_w;
  logic        second;
  logic        us_l;

  logic [7:0]  psh_mask, pul_mask, go_mask, mask_nx;
  logic [2:0]  hi_idx, lo_idx, cur_idx;
  logic [15:0] cur_word;
  logic        is16, last_byte;

  assign psh_mask = postbyte | (psh_all ? 8'hFF : 8'h00) | (psh_cc ? 8'h01 : 8'h00)
                  | (psh_pc ? 8'h80 : 8'h00);
  assign pul_mask = postbyte | (rti_cc ? 8'h01 : 8'h00)
                  | (rti_other ? (cc_e ? 8'hFE : 8'h80) : 8'h00);
  assign go_mask  = psh_go ? psh_mask : pul_mask;

  always_comb begin
    hi_idx = 3'd0;
    lo_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (mask[i]) hi_idx = 3'(i);
    for (int i = 7; i >= 0; i--)
      if (mask[i]) lo_idx = 3'(i);
  end

  // Push walks from PC down to CC, pull from CC up to PC
  assign cur_idx = (state == PUSH) ? hi_idx : lo_idx;
  assign is16    = cur_idx[2];

  always_comb begin
    cur_word = 16'h0000;
    case (cur_idx)
      3'd0: cur_word = {8'h00, rcc};
      3'd1: cur_word = {8'h00, ra};
      3'd2: cur_word = {8'h00, rb};
      3'd3: cur_word = {8'h00, rdp};
      3'd4: cur_word = rx;
      3'd5: cur_word = ry;
      3'd6: cur_word = rother;
      default: cur_word = rpc;
    endcase
  end

  assign last_byte = !is16 || second;
  assign mask_nx   = mask & ~(8'h01 << cur_idx);

  assign we         = (state == PUSH);
  assign rd         = (state == PULL);
  assign addr       = (state == PUSH) ? sp_w - 16'd1 : (state == PULL) ? sp_w : 16'h0000;
  assign dout       = (state != PUSH) ? 8'h00 : (is16 && second) ? cur_word[15:8] : cur_word[7:0];
  assign stack_busy = (state != IDLE) || psh_go || pul_go;
  assign sp_we      = (state == FIN);
  assign sp_out     = sp_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= 8'h00;
      sp_w     <= 16'h0000;
      second   <= 1'b0;
      us_l     <= 1'b0;
      pul_we   <= 1'b0;
      pul_sel  <= 3'd0;
      pul_hi   <= 1'b0;
      pul_data <= 8'h00;
    end else if (cen) begin
      pul_we <= 1'b0;
      case (state)
        IDLE: if (psh_go || pul_go) begin
          mask   <= go_mask;
          us_l   <= us_sel;
          sp_w   <= sp_in;
          second <= 1'b0;
          state  <= (go_mask == 8'h00) ? FIN : psh_go ? PUSH : PULL;
        end
        PUSH, PULL: if (!mem_busy) begin
          if (state == PUSH) begin
            sp_w <= sp_w - 16'd1;
          end else begin
            sp_w     <= sp_w + 16'd1;
            pul_we   <= 1'b1;
            pul_data <= din;
            pul_sel  <= cur_idx;
            pul_hi   <= is16 && !second;
          end
          if (last_byte) begin
            second <= 1'b0;
            mask   <= mask_nx;
            if (mask_nx == 8'h00) state <= FIN;
          end else begin
            second <= 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
